// File: rtl/systolic_ws_pkg.sv
// Shared width constants and requantization helper for the weight-stationary
// systolic array datapath and its result-drain stage.
package systolic_ws_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = DATA_W * 4;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam acc_t DATA_MAX = acc_t'((2 ** (DATA_W - 1)) - 1);
  localparam acc_t DATA_MIN = -DATA_MAX - acc_t'(1);

  // Arithmetic right shift, then clamp into the signed output range.
  function automatic data_t requant_sat(input acc_t acc, input int unsigned shift);
    acc_t t;
    t = acc >>> shift;
    if (t > DATA_MAX)      return data_t'(DATA_MAX);
    else if (t < DATA_MIN) return data_t'(DATA_MIN);
    else                   return data_t'(t);
  endfunction

endpackage

// File: rtl/systolic_ws_requant.sv
// Per-column combinational requantizer: signed shift right by SHIFT, then
// saturate to DATA_WIDTH.
module systolic_ws_requant #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH * 4,
  parameter int SHIFT      = 8
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [ACC_WIDTH-DATA_WIDTH:0] upper;

  // In range exactly when every bit above the output sign bit matches it.
  always_comb begin
    shifted = signed'(acc_i) >>> SHIFT;
    upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
    if (upper == '0 || upper == '1) begin
      q_o = shifted[DATA_WIDTH-1:0];
    end else if (shifted[ACC_WIDTH-1]) begin
      q_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      q_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/systolic_ws_drain.sv
// Result-drain stage: absorbs skewed per-column writes from the systolic array,
// requantizes them, and streams complete rows in order over valid/ready.
module systolic_ws_drain
  import systolic_ws_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int ROW_NUM        = 8,
  parameter int COL_NUM        = 8,
  parameter int SHIFT          = 8,
  parameter int ACC_WIDTH      = DATA_WIDTH * 4,
  parameter int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ACC_WIDTH-1:0]      col_data_in [0:COL_NUM-1],
  input  logic [ROW_ADDR_WIDTH-1:0] col_wraddr  [0:COL_NUM-1],
  input  logic                      col_wr_en   [0:COL_NUM-1],
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [DATA_WIDTH-1:0]     out_data    [0:COL_NUM-1],
  output logic [ROW_ADDR_WIDTH-1:0] out_row_idx,
  output logic                      out_last,
  output logic                      err
);

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROW_NUM - 1);

  logic [DATA_WIDTH-1:0]     rq     [0:COL_NUM-1];
  logic [DATA_WIDTH-1:0]     buf_q  [0:ROW_NUM-1][0:COL_NUM-1];
  logic [DATA_WIDTH-1:0]     buf_d  [0:ROW_NUM-1][0:COL_NUM-1];
  logic [COL_NUM-1:0]        mask_q [0:ROW_NUM-1];
  logic [COL_NUM-1:0]        mask_d [0:ROW_NUM-1];
  logic [ROW_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                      err_q, err_d;
  logic                      fire;

  for (genvar c = 0; c < COL_NUM; c++) begin : g_rq
    systolic_ws_requant #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SHIFT     (SHIFT)
    ) u_rq (
      .acc_i(col_data_in[c]),
      .q_o  (rq[c])
    );
  end

  assign out_val     = &mask_q[rd_ptr_q];
  assign out_data    = buf_q[rd_ptr_q];
  assign out_row_idx = rd_ptr_q;
  assign out_last    = out_val && (rd_ptr_q == LAST_ROW);
  assign err         = err_q;
  assign fire        = out_val && out_rdy;

  // The drain clear is applied before writes, so a refill of the row being
  // handed off in the same cycle lands on an empty slot.
  always_comb begin
    buf_d    = buf_q;
    mask_d   = mask_q;
    err_d    = err_q;
    rd_ptr_d = rd_ptr_q;
    if (fire) begin
      mask_d[rd_ptr_q] = '0;
      rd_ptr_d = (rd_ptr_q == LAST_ROW) ? '0 : rd_ptr_q + 1'b1;
    end
    for (int unsigned c = 0; c < COL_NUM; c++) begin
      if (col_wr_en[c]) begin
        if (int'(col_wraddr[c]) >= ROW_NUM || mask_d[col_wraddr[c]][c]) begin
          err_d = 1'b1;
        end else begin
          mask_d[col_wraddr[c]][c] = 1'b1;
          buf_d[col_wraddr[c]][c]  = rq[c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q    <= '{default: '0};
      mask_q   <= '{default: '0};
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      mask_q   <= mask_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_systolic_ws_drain.sv
// Self-checking bench for systolic_ws_drain: 4x4 tile, SHIFT=8, scoreboard of
// expected rows compared as the DUT hands them off.
module tb_systolic_ws_drain;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } row_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] col_data_in [0:COLS-1];
  logic [1:0]  col_wraddr  [0:COLS-1];
  logic        col_wr_en   [0:COLS-1];
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  out_data    [0:COLS-1];
  logic [1:0]  out_row_idx;
  logic        out_last;
  logic        err;
  logic [31:0] out_flat;

  row_t sb[$];
  row_t exp_r;
  int   checks = 0;
  int   errors = 0;

  systolic_ws_drain #(
    .DATA_WIDTH(8),
    .ROW_NUM   (ROWS),
    .COL_NUM   (COLS),
    .SHIFT     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .col_data_in(col_data_in),
    .col_wraddr (col_wraddr),
    .col_wr_en  (col_wr_en),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_row_idx(out_row_idx),
    .out_last   (out_last),
    .err        (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < COLS; c++) out_flat[c*8 +: 8] = out_data[c];
  end

  function automatic logic [7:0] model(input logic [31:0] a);
    logic signed [31:0] t;
    t = $signed(a) >>> 8;
    if (t > 127)  return 8'h7f;
    if (t < -128) return 8'h80;
    return t[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int c = 0; c < COLS; c++) begin
      col_wr_en[c]   = 1'b0;
      col_wraddr[c]  = '0;
      col_data_in[c] = '0;
    end
  endtask

  task automatic set_col(input int c, input int r, input logic [31:0] v);
    col_wr_en[c]   = 1'b1;
    col_wraddr[c]  = 2'(r);
    col_data_in[c] = v;
  endtask

  task automatic push_row(input int r, input logic [31:0] a0, a1, a2, a3);
    row_t e;
    e.idx  = 2'(r);
    e.data = {model(a3), model(a2), model(a1), model(a0)};
    sb.push_back(e);
  endtask

  task automatic fill_row(input int r, input logic [31:0] a0, a1, a2, a3, input bit push);
    set_col(0, r, a0); set_col(1, r, a1); set_col(2, r, a2); set_col(3, r, a3);
    if (push) push_row(r, a0, a1, a2, a3);
  endtask

  task automatic do_reset();
    idle();
    out_rdy = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    sb.delete();
  endtask

  task automatic test_reset();
    idle();
    out_rdy = 1'b0;
    reset   = 1'b1;
    #3;
    checks++;
    if (out_val !== 1'b0 || err !== 1'b0 || out_last !== 1'b0 || out_row_idx !== 2'd0 || out_flat !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: val=%b err=%b last=%b idx=%0d data=%h, expected all zero",
               out_val, err, out_last, out_row_idx, out_flat);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (out_val !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: val=%b err=%b, expected 0 0", out_val, err);
    end
  endtask

  // Column c writes row r during cycle r+c; rows must appear one per cycle.
  task automatic test_skew();
    do_reset();
    out_rdy = 1'b1;
    for (int r = 0; r < ROWS; r++) push_row(r, 32'h300, 32'h300, 32'h300, 32'h300);
    for (int t = 0; t < 9; t++) begin
      if (out_val) begin
        exp_r = sb.pop_front();
        checks++;
        if (out_row_idx !== exp_r.idx || out_flat !== exp_r.data || out_last !== (exp_r.idx == 2'd3)
            || t != int'(exp_r.idx) + 4) begin
          errors++;
          $display("FAIL skew_row: cycle=%0d idx=%0d data=%h last=%b, expected cycle=%0d idx=%0d data=%h",
                   t, out_row_idx, out_flat, out_last, int'(exp_r.idx) + 4, exp_r.idx, exp_r.data);
        end
      end
      idle();
      for (int c = 0; c < COLS; c++)
        if (t - c >= 0 && t - c < ROWS) set_col(c, t - c, 32'h300);
      tick();
    end
    idle();
    checks++;
    if (sb.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL skew_done: rows_left=%0d err=%b, expected 0 0", sb.size(), err);
      sb.delete();
    end
  endtask

  task automatic test_saturation();
    logic [31:0] rv [4];
    do_reset();
    out_rdy = 1'b1;
    fill_row(0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FF80, 32'h0000_7F00, 1'b0);
    tick();
    idle();
    checks++;
    if (out_val !== 1'b1 || out_row_idx !== 2'd0 || out_flat !== {8'h7f, 8'hff, 8'h80, 8'h7f}) begin
      errors++;
      $display("FAIL sat_const: val=%b idx=%0d data=%h, expected 1 0 7fff807f", out_val, out_row_idx, out_flat);
    end
    tick();
    for (int c = 0; c < 4; c++) rv[c] = $urandom;
    fill_row(1, rv[0], rv[1], rv[2], rv[3], 1'b1);
    tick();
    idle();
    exp_r = sb.pop_front();
    checks++;
    if (out_val !== 1'b1 || out_row_idx !== 2'd1 || out_flat !== exp_r.data) begin
      errors++;
      $display("FAIL sat_random: val=%b idx=%0d data=%h, expected 1 1 %h", out_val, out_row_idx, out_flat, exp_r.data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    fill_row(0, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400, 1'b1);
    tick();
    idle();
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (out_val !== 1'b1 || out_row_idx !== 2'd0 || out_flat !== sb[0].data || out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle=%0d val=%b idx=%0d data=%h, expected 1 0 %h", n, out_val, out_row_idx, out_flat, sb[0].data);
      end
      idle();
      if (n >= 1 && n <= 3)
        fill_row(n, 32'((n*16) << 8), 32'((n*16+1) << 8), 32'((n*16+2) << 8), 32'((n*16+3) << 8), 1'b1);
      tick();
    end
    idle();
    out_rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_r = sb.pop_front();
      checks++;
      if (out_val !== 1'b1 || out_row_idx !== exp_r.idx || out_flat !== exp_r.data || out_last !== (exp_r.idx == 2'd3)) begin
        errors++;
        $display("FAIL bp_drain: val=%b idx=%0d data=%h last=%b, expected 1 %0d %h", out_val, out_row_idx, out_flat, out_last, exp_r.idx, exp_r.data);
      end
      tick();
    end
    checks++;
    if (out_val !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: val=%b err=%b, expected 0 0", out_val, err);
    end
  endtask

  task automatic test_duplicate();
    do_reset();
    set_col(2, 1, 32'h0000_0500);
    tick();
    idle();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL dup_first: err=%b, expected 0", err);
    end
    set_col(2, 1, 32'h0000_0900);
    tick();
    idle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL dup_err: err=%b, expected 1", err);
    end
    fill_row(0, 32'h0000_0a00, 32'h0000_0b00, 32'h0000_0c00, 32'h0000_0d00, 1'b1);
    tick();
    idle();
    set_col(0, 1, 32'h0000_0100); set_col(1, 1, 32'h0000_0200); set_col(3, 1, 32'h0000_0400);
    push_row(1, 32'h0000_0100, 32'h0000_0200, 32'h0000_0500, 32'h0000_0400);
    tick();
    idle();
    out_rdy = 1'b1;
    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      if (out_val) begin
        exp_r = sb.pop_front();
        checks++;
        if (out_row_idx !== exp_r.idx || out_flat !== exp_r.data) begin
          errors++;
          $display("FAIL dup_drain: idx=%0d data=%h, expected %0d %h", out_row_idx, out_flat, exp_r.idx, exp_r.data);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL dup_done: rows_left=%0d err=%b, expected 0 1", sb.size(), err);
      sb.delete();
    end
  endtask

  task automatic test_refill();
    do_reset();
    out_rdy = 1'b1;
    fill_row(0, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400, 1'b1);
    tick();
    idle();
    exp_r = sb.pop_front();
    checks++;
    if (out_val !== 1'b1 || out_row_idx !== 2'd0 || out_flat !== exp_r.data) begin
      errors++;
      $display("FAIL refill_row0: val=%b idx=%0d data=%h, expected 1 0 %h", out_val, out_row_idx, out_flat, exp_r.data);
    end
    set_col(0, 0, 32'h0000_0700);
    tick();
    idle();
    checks++;
    if (err !== 1'b0 || out_row_idx !== 2'd1) begin
      errors++;
      $display("FAIL refill_err: err=%b idx=%0d, expected 0 1", err, out_row_idx);
    end
    out_rdy = 1'b0;
    for (int r = 1; r < ROWS; r++) begin
      fill_row(r, 32'(r << 12), 32'(r << 12), 32'(r << 12), 32'(r << 12), 1'b1);
      tick();
    end
    idle();
    out_rdy = 1'b1;
    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      if (out_val) begin
        exp_r = sb.pop_front();
        checks++;
        if (out_row_idx !== exp_r.idx || out_flat !== exp_r.data) begin
          errors++;
          $display("FAIL refill_drain: idx=%0d data=%h, expected %0d %h", out_row_idx, out_flat, exp_r.idx, exp_r.data);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0 || out_val !== 1'b0 || out_row_idx !== 2'd0) begin
      errors++;
      $display("FAIL refill_wrap: rows_left=%0d val=%b idx=%0d, expected 0 0 0", sb.size(), out_val, out_row_idx);
      sb.delete();
    end
    set_col(1, 0, 32'h0000_0800); set_col(2, 0, 32'h0000_0900); set_col(3, 0, 32'h0000_0a00);
    tick();
    idle();
    checks++;
    if (out_val !== 1'b1 || out_flat !== {8'h0a, 8'h09, 8'h08, 8'h07} || err !== 1'b0) begin
      errors++;
      $display("FAIL refill_kept: val=%b data=%h err=%b, expected 1 0a090807 0", out_val, out_flat, err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_row(0, 32'h0000_1100, 32'h0000_1200, 32'h0000_1300, 32'h0000_1400, 1'b0);
    tick();
    idle();
    set_col(0, 1, 32'h0000_2100); set_col(1, 1, 32'h0000_2200);
    tick();
    idle();
    set_col(1, 1, 32'h0000_2300);
    tick();
    idle();
    checks++;
    if (out_val !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: val=%b err=%b, expected 1 1", out_val, err);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_val !== 1'b0 || err !== 1'b0 || out_flat !== 32'h0 || out_row_idx !== 2'd0) begin
      errors++;
      $display("FAIL rst_async: val=%b err=%b data=%h idx=%0d, expected 0 0 0 0", out_val, err, out_flat, out_row_idx);
    end
    #1;
    reset = 1'b0;
    tick();
    fill_row(0, 32'h0000_3100, 32'h0000_3200, 32'h0000_3300, 32'h0000_3400, 1'b1);
    tick();
    idle();
    set_col(2, 1, 32'h0000_4300); set_col(3, 1, 32'h0000_4400);
    tick();
    idle();
    out_rdy = 1'b1;
    exp_r = sb.pop_front();
    checks++;
    if (out_val !== 1'b1 || out_row_idx !== 2'd0 || out_flat !== exp_r.data) begin
      errors++;
      $display("FAIL rst_row0: val=%b idx=%0d data=%h, expected 1 0 %h", out_val, out_row_idx, out_flat, exp_r.data);
    end
    tick();
    out_rdy = 1'b0;
    checks++;
    if (out_val !== 1'b0 || out_row_idx !== 2'd1) begin
      errors++;
      $display("FAIL rst_partial: val=%b idx=%0d, expected 0 1", out_val, out_row_idx);
    end
    set_col(0, 1, 32'h0000_4100); set_col(1, 1, 32'h0000_4200);
    push_row(1, 32'h0000_4100, 32'h0000_4200, 32'h0000_4300, 32'h0000_4400);
    tick();
    fill_row(2, 32'h0000_5100, 32'h0000_5200, 32'h0000_5300, 32'h0000_5400, 1'b1);
    tick();
    fill_row(3, 32'h0000_6100, 32'h0000_6200, 32'h0000_6300, 32'h0000_6400, 1'b1);
    tick();
    idle();
    out_rdy = 1'b1;
    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      if (out_val) begin
        exp_r = sb.pop_front();
        checks++;
        if (out_row_idx !== exp_r.idx || out_flat !== exp_r.data || out_last !== (exp_r.idx == 2'd3)) begin
          errors++;
          $display("FAIL rst_drain: idx=%0d data=%h last=%b, expected %0d %h", out_row_idx, out_flat, out_last, exp_r.idx, exp_r.data);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_done: rows_left=%0d err=%b, expected 0 0", sb.size(), err);
      sb.delete();
    end
  endtask

  initial begin
    reset   = 1'b1;
    out_rdy = 1'b0;
    idle();
    test_reset();
    test_skew();
    test_saturation();
    test_backpressure();
    test_duplicate();
    test_refill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_ws_drain.md
# systolic_ws_drain

Result-drain stage directly downstream of the weight-stationary systolic array. It captures the skewed per-column result writes (data, row address, write enable per column) and requantizes each 4×-wide accumulator to DATA_WIDTH with arithmetic shift and saturation. It reassembles complete rows and streams them, in row order, on a valid/ready interface toward the result SRAM/next layer. The array has no backpressure, so this block buffers a full tile and flags any write it cannot absorb.

## Interface
Parameters:
- DATA_WIDTH, 8, output element width (signed)
- ROW_NUM, 8, rows per tile; buffer depth
- COL_NUM, 8, columns (lanes) per row
- SHIFT, 8, arithmetic right-shift applied before saturation (0..ACC_WIDTH-1)
- ACC_WIDTH, DATA_WIDTH*4, input accumulator width (derived, not set manually)
- ROW_ADDR_WIDTH, $clog2(ROW_NUM), derived

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- col_data_in  in  [ACC_WIDTH-1:0] x [0:COL_NUM-1]  signed accumulator per column
- col_wraddr  in  [ROW_ADDR_WIDTH-1:0] x [0:COL_NUM-1]  target row per column
- col_wr_en  in  1 x [0:COL_NUM-1]  per-column write strobe
- out_val  out  1  full row available
- out_rdy  in  1  consumer accepts row
- out_data  out  [DATA_WIDTH-1:0] x [0:COL_NUM-1]  requantized row
- out_row_idx  out  ROW_ADDR_WIDTH  index of row on out_data
- out_last  out  1  out_row_idx == ROW_NUM-1 while out_val
- err  out  1  sticky write-error flag

## Operation
- Storage: ROW_NUM x COL_NUM x DATA_WIDTH registers plus ROW_NUM x COL_NUM fill mask; rd_ptr (ROW_ADDR_WIDTH).
- Write: for each column c with col_wr_en[c]=1, row r=col_wraddr[c]: store requant(col_data_in[c]) into buf[r][c], set mask[r][c]. Columns independent; all COL_NUM may write in one cycle.
- Requant: t = col_data_in >>> SHIFT (signed); result = t clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Row complete when mask[rd_ptr] is all ones; out_val = complete(rd_ptr), out_data = buf[rd_ptr], out_row_idx = rd_ptr.
- Handshake out_val && out_rdy: clear mask[rd_ptr], rd_ptr <= (rd_ptr==ROW_NUM-1) ? 0 : rd_ptr+1.
- Rows drain strictly in order; a complete row r != rd_ptr waits.
- Errors (set err, write dropped, no state change for that column): write to an already-set mask bit; col_wraddr >= ROW_NUM (non-power-of-2 ROW_NUM only).
- Same-cycle clear and write to same row/column: clear applies first, write is accepted, bit ends set, no error.
- err cleared only by reset.

## Timing
- Reset values: out_val 0, out_data all 0, out_row_idx 0, out_last 0, err 0, mask all 0, rd_ptr 0.
- Latency: final column write of row rd_ptr sampled at edge k -> out_val high in cycle after edge k (1 cycle); no combinational path from col_* to out_*.
- out_val, out_data, out_row_idx, out_last combinational from registers only; stable while out_val && !out_rdy.
- out_rdy may depend on out_val; out_val never depends on out_rdy.
- Back-to-back complete rows drain one per cycle with out_rdy held high.
- err rises the cycle after the offending write edge.
- Reset mid-tile: all partial rows discarded; next write starts from empty buffer.

## Structure
- Package systolic_ws_pkg: acc_t/data_t width constants and function requant_sat(acc, shift) returning data_t; shared with the array's dpath for width consistency.
- One sub-module: systolic_ws_requant (per-column combinational shift+saturate, instantiated COL_NUM times); mask/buffer/pointer logic in top.

## Test plan
- ROW_NUM=4, COL_NUM=4, SHIFT=8: skewed writes (column c writes row r at cycle r+c) with values 0x0000_0300 -> rows emitted 0..3, each element 3, out_last only on row 3, one row per cycle with out_rdy=1.
- Saturation: acc 0x0001_0000 -> 127; 0xFFFF_0000 -> -128; 0xFFFF_FF80 -> -1; 0x0000_7F00 -> 127.
- Backpressure: out_rdy=0 for 10 cycles after row 0 completes -> out_val held, out_data/out_row_idx stable; then rdy=1 drains rows 0..3 in order, no err.
- Duplicate write: column 2 writes row 1 twice before drain -> err=1 next cycle, first value retained on output.
- Same-cycle drain+refill: row 0 handshakes while column 0 writes row 0 of next tile -> no err, mask[0][0] set after edge.
- Reset asserted asynchronously with rows 0-1 partially filled -> out_val=0, err=0 immediately; subsequent full tile drains from row 0.
